sq_fetch_sequencer: RTL

- Produces the memory-cycle time pulses T01..T12 and the next-instruction fetch handshake that feed the SQ register.
- At the last memory cycle (MCT) of each instruction it issues NISQ, fetches the next instruction word from memory and drives the order-code write lines.
- It also drives the write strobe so that SQ latches WL16..WL10 at T12.
- It sits between the memory interface (erasable/fixed buffer) and the SQ register on the central write bus.

---
 rtl/agc_timing_pkg.sv | 32 +++
 rtl/agc_tp_counter.sv | 47 ++++
 rtl/sq_fetch_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/agc_timing_pkg.sv
`default_nettype none
// ============================================================================
// Package     : agc_timing_pkg
// Description : Shared timing constants, state encoding and time-pulse type
//               for the SQ fetch sequencer and its time-pulse counter.
//               NT         - time pulses per memory cycle (MCT), counted 1..NT
//               STALL_TP   - pulse at which a fetch MCT waits for memory data
//               START_ADDR - first fetch address after a GOJAM restart
// Revision    : 1.0 - initial release
// ============================================================================
package agc_timing_pkg;

  localparam int TP_W = 4;
  localparam int NT = 12;
  localparam int STALL_TP = 6;
  localparam logic [11:0] START_ADDR = 12'o4000;

  typedef logic [TP_W-1:0] tp_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    LOAD  = 2'd2
  } seq_state_e;

  // Time-pulse number as a counter-width value.
  function automatic tp_t tp_val(input int n);
    return tp_t'(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/agc_tp_counter.sv
`default_nettype none
// ============================================================================
// Module      : agc_tp_counter
// Description : Time-pulse counter running 1..COUNT_MAX and wrapping to 1.
//               The count freezes while hold is high. T02 and T12_n are
//               registered alongside the count so they align with tp.
// Ports       : clk   - clock, one time pulse per cycle
//               rst   - synchronous active-high clear (tp=1)
//               hold  - freeze the count this cycle
//               tp    - current time pulse number
//               t02   - high while tp==2
//               t12_n - low while tp==COUNT_MAX
// Revision    : 1.0 - initial release
// ============================================================================
module agc_tp_counter
  import agc_timing_pkg::*;
#(
  parameter int COUNT_MAX = NT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  output logic [TP_W-1:0] tp,
  output logic            t02,
  output logic            t12_n
);

  logic [TP_W-1:0] tp_next;

  always_comb begin
    tp_next = (tp == tp_val(COUNT_MAX)) ? tp_val(1) : tp + tp_val(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tp    <= tp_val(1);
      t02   <= 1'b0;
      t12_n <= 1'b1;
    end else if (!hold) begin
      tp    <= tp_next;
      t02   <= (tp_next == tp_val(2));
      t12_n <= (tp_next != tp_val(COUNT_MAX));
    end
  end

endmodule
`default_nettype wire

// File: rtl/sq_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sq_fetch_sequencer
// Description : Generates the MCT time pulses and the next-instruction fetch
//               handshake feeding the SQ register. At the last MCT of an
//               instruction it pulses NISQ, fetches the next word and, in the
//               following fetch MCT, strobes it onto the write lines at T12.
// Ports       : SIM_CLK   - clock, one time pulse per cycle
//               SIM_RST   - synchronous active-high reset
//               GOJAM     - restart; as reset, but arms a START_ADDR fetch
//               INST_DONE - current MCT is the instruction's last (TP1..10)
//               Z_ADDR    - next instruction address
//               MEM_ACK   - memory data valid pulse
//               MEM_DATA  - memory word, valid with MEM_ACK
//               MEM_REQ   - fetch request, held until MEM_ACK
//               MEM_ADDR  - fetch address, stable while MEM_REQ is high
//               TP        - current time pulse 1..12
//               T02       - high while TP==2
//               T12_n     - low while TP==12
//               NISQ      - one-cycle next-instruction pulse at TP11
//               WT_n      - write-bus strobe, active low
//               WL_n      - write lines, active low, all ones when idle
//               FETCH_MCT - current MCT is an instruction fetch
// Revision    : 1.0 - initial release
// ============================================================================
module sq_fetch_sequencer
  import agc_timing_pkg::*;
(
  input  logic            SIM_CLK,
  input  logic            SIM_RST,
  input  logic            GOJAM,
  input  logic            INST_DONE,
  input  logic [11:0]     Z_ADDR,
  input  logic            MEM_ACK,
  input  logic [15:0]     MEM_DATA,
  output logic            MEM_REQ,
  output logic [11:0]     MEM_ADDR,
  output logic [TP_W-1:0] TP,
  output logic            T02,
  output logic            T12_n,
  output logic            NISQ,
  output logic            WT_n,
  output logic [15:0]     WL_n,
  output logic            FETCH_MCT
);

  localparam logic [TP_W-1:0] TP_NISQ_PRE = tp_val(NT - 2);
  localparam logic [TP_W-1:0] TP_LOAD_PRE = tp_val(NT - 1);
  localparam logic [TP_W-1:0] TP_LAST     = tp_val(NT);
  localparam logic [TP_W-1:0] TP_STALL    = tp_val(STALL_TP);

  seq_state_e  state;
  logic        pending_nisq;
  logic        armed;       // a fetch is owed after reset/GOJAM
  logic        use_start;   // next fetch goes to START_ADDR
  logic        data_ok;     // fetch_buf holds this MCT's word
  logic [15:0] fetch_buf;

  logic restart;
  logic ack_ok;
  logic tp_hold;
  logic next_fetch;

  assign restart    = SIM_RST | GOJAM;
  // An acknowledge only counts against an outstanding request, so strays
  // outside a fetch and late ones after an abort are dropped.
  assign ack_ok     = MEM_ACK & MEM_REQ;
  // Freeze at the stall pulse until the word arrives; the same term keeps
  // the counter frozen for the whole STALL state.
  assign tp_hold    = FETCH_MCT & MEM_REQ & ~MEM_ACK & (TP == TP_STALL);
  assign next_fetch = pending_nisq | armed;

  agc_tp_counter #(
    .COUNT_MAX(NT)
  ) u_tp_counter (
    .clk  (SIM_CLK),
    .rst  (restart),
    .hold (tp_hold),
    .tp   (TP),
    .t02  (T02),
    .t12_n(T12_n)
  );

  always_ff @(posedge SIM_CLK) begin
    if (restart) begin
      state        <= RUN;
      pending_nisq <= 1'b0;
      armed        <= 1'b1;
      use_start    <= GOJAM;
      data_ok      <= 1'b0;
      fetch_buf    <= 16'h0000;
      MEM_REQ      <= 1'b0;
      MEM_ADDR     <= 12'h000;
      NISQ         <= 1'b0;
      WT_n         <= 1'b1;
      WL_n         <= 16'hFFFF;
      FETCH_MCT    <= 1'b1;
    end else begin
      NISQ <= 1'b0;

      if (INST_DONE && (TP <= TP_NISQ_PRE)) begin
        pending_nisq <= 1'b1;
      end

      // INST_DONE seen in the TP10 cycle itself still fires NISQ at TP11.
      if (TP == TP_NISQ_PRE) begin
        NISQ <= pending_nisq | INST_DONE;
      end

      if (ack_ok) begin
        fetch_buf <= MEM_DATA;
        data_ok   <= 1'b1;
        MEM_REQ   <= 1'b0;
      end

      case (state)
        RUN: begin
          if (tp_hold) begin
            state <= STALL;
          end else if ((TP == TP_LOAD_PRE) && FETCH_MCT && data_ok) begin
            state <= LOAD;
            WT_n  <= 1'b0;
            WL_n  <= ~fetch_buf;
          end
        end
        STALL: begin
          if (ack_ok) begin
            state <= RUN;
          end
        end
        LOAD: begin
          state <= RUN;
          WT_n  <= 1'b1;
          WL_n  <= 16'hFFFF;
        end
        default: state <= RUN;
      endcase

      // MCT boundary: decide whether the next MCT fetches and launch it.
      if (TP == TP_LAST) begin
        FETCH_MCT    <= next_fetch;
        pending_nisq <= 1'b0;
        armed        <= 1'b0;
        data_ok      <= 1'b0;
        if (next_fetch) begin
          MEM_REQ   <= 1'b1;
          MEM_ADDR  <= use_start ? START_ADDR : Z_ADDR;
          use_start <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
